// File: rtl/fifo2axi.sv
// FIFO-to-AXI-stream egress: pops packed words from a 1-cycle-latency FIFO into a
// 3-entry skid buffer whose head drives the stream; tx_en stops only on packet ends.
module fifo2axi #(
   parameter int DW    = 8,
   parameter int UDW   = 10,
   parameter int U_DLY = 1,
   parameter int DEW   = DW/8,
   parameter int FW    = DW+DEW+UDW+1
) (
   input  logic           clk_sys,
   input  logic           rst_n,
   input  logic           tx_en,
   output logic           tx_busy,
   output logic           tx_pkt_done,
   output logic [15:0]    tx_pkt_cnt,
   output logic           fifo_rd_en,
   input  logic [FW-1:0]  fifo_rd_data,
   input  logic           fifo_empty,
   input  logic           axi_ready,
   output logic           axi_valid,
   output logic [DW-1:0]  axi_data,
   output logic           axi_last,
   output logic [DEW-1:0] axi_keep,
   output logic [UDW-1:0] axi_user
);

   typedef struct packed {
      logic [UDW-1:0] user;
      logic [DEW-1:0] keep;
      logic           last;
      logic [DW-1:0]  data;
   } word_t;

   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

   // U_DLY only matters for delay-annotated simulation builds; this logic uses zero-delay NBAs.
   if (U_DLY > 0) begin : g_sim_dly
   end

   state_t      state, state_nxt;
   word_t [2:0] buf_q;
   word_t       rd_word;
   logic [1:0]  buf_cnt;
   logic [1:0]  wr_idx;
   logic [2:0]  occ;
   logic        rd_pend;
   logic        last_acc;
   logic        push, pop;

   assign rd_word = fifo_rd_data;
   assign pop     = axi_valid & axi_ready;
   assign push    = rd_pend;
   assign wr_idx  = pop ? buf_cnt - 2'd1 : buf_cnt;
   assign occ     = {1'b0, buf_cnt} + {2'b00, rd_pend};

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Reads depend on registered state only, so axi_ready never reaches fifo_rd_en.
   always_comb begin
      state_nxt  = state;
      fifo_rd_en = 1'b0;
      case (state)
         IDLE: if (tx_en) state_nxt = RUN;
         RUN: begin
            fifo_rd_en = !fifo_empty && (occ < 3'd3);
            if (!tx_en) state_nxt = STOP;
         end
         STOP: begin
            // One read at a time so the packet end is seen before another word is requested.
            fifo_rd_en = !fifo_empty && !rd_pend && !last_acc && (buf_cnt != 2'd3);
            if (tx_en)                         state_nxt = RUN;
            else if (rd_pend && rd_word.last)  state_nxt = IDLE;
            else if (!rd_pend && last_acc)     state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // last_acc starts at 1: before any word is taken we sit on a packet boundary.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         buf_q    <= '0;
         buf_cnt  <= 2'd0;
         rd_pend  <= 1'b0;
         last_acc <= 1'b1;
      end else begin
         rd_pend <= fifo_rd_en;
         if (pop) begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= buf_q[2];
         end
         if (push) begin
            buf_q[wr_idx] <= rd_word;
            last_acc      <= rd_word.last;
         end
         case ({push, pop})
            2'b10:   buf_cnt <= buf_cnt + 2'd1;
            2'b01:   buf_cnt <= buf_cnt - 2'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         tx_pkt_done <= 1'b0;
         tx_pkt_cnt  <= 16'd0;
      end else begin
         tx_pkt_done <= pop & axi_last;
         if (pop & axi_last) tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
      end
   end

   assign axi_valid = (buf_cnt != 2'd0);
   assign axi_data  = buf_q[0].data;
   assign axi_last  = buf_q[0].last;
   assign axi_keep  = buf_q[0].keep;
   assign axi_user  = buf_q[0].user;
   assign tx_busy   = (state != IDLE) || (buf_cnt != 2'd0);

endmodule

// File: tb/tb_fifo2axi.sv
// Scoreboard bench for fifo2axi: behavioural 1-cycle-latency FIFO feeds the DUT,
// expected words queued on push and compared on every stream handshake.
module tb_fifo2axi;
   localparam int DW  = 8;
   localparam int UDW = 10;
   localparam int DEW = DW/8;
   localparam int FW  = DW+DEW+UDW+1;

   logic           clk_sys = 1'b0;
   logic           rst_n = 1'b1;
   logic           tx_en = 1'b0;
   logic           axi_ready = 1'b0;
   logic [FW-1:0]  fifo_rd_data = '0;
   logic           fifo_empty;
   logic           tx_busy, tx_pkt_done, fifo_rd_en;
   logic [15:0]    tx_pkt_cnt;
   logic           axi_valid, axi_last;
   logic [DW-1:0]  axi_data;
   logic [DEW-1:0] axi_keep;
   logic [UDW-1:0] axi_user;

   fifo2axi #(.DW(DW), .UDW(UDW)) dut (
      .clk_sys(clk_sys), .rst_n(rst_n), .tx_en(tx_en), .tx_busy(tx_busy),
      .tx_pkt_done(tx_pkt_done), .tx_pkt_cnt(tx_pkt_cnt), .fifo_rd_en(fifo_rd_en),
      .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .axi_ready(axi_ready),
      .axi_valid(axi_valid), .axi_data(axi_data), .axi_last(axi_last),
      .axi_keep(axi_keep), .axi_user(axi_user)
   );

   always #5 clk_sys = ~clk_sys;

   // external FIFO model
   logic [FW-1:0] mem [0:255];
   int wr_ptr = 0, rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clk_sys) begin
      if (fifo_rd_en && !fifo_empty) begin
         fifo_rd_data <= mem[rd_ptr[7:0]];
         rd_ptr       <= rd_ptr + 1;
      end
   end

   int checks = 0, errors = 0;
   logic [FW-1:0] exp_q [$];
   int hs_cnt = 0, done_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic push_word(input logic [DW-1:0] d, input logic last, input logic [UDW-1:0] u);
      logic [FW-1:0] w;
      w = {u, DEW'(d), last, d};
      mem[wr_ptr[7:0]] = w;
      wr_ptr++;
      exp_q.push_back(w);
   endtask

   task automatic wait_hs(input int target, input int max_cyc);
      for (int k = 0; k < max_cyc && hs_cnt < target; k++) tick();
      if (hs_cnt < target) chk("tmo_hs", hs_cnt, target);
   endtask

   task automatic wait_done(input int target, input int max_cyc);
      for (int k = 0; k < max_cyc && done_cnt < target; k++) tick();
      if (done_cnt < target) chk("tmo_done", done_cnt, target);
   endtask

   // stream monitor: scoreboard, hold-stability and underflow checks
   initial begin
      logic [FW-1:0] cur, hold_w;
      logic          hold_q;
      hold_q = 1'b0;
      hold_w = '0;
      forever begin
         @(negedge clk_sys);
         cur = {axi_user, axi_keep, axi_last, axi_data};
         if (hold_q) chk("hold_stable", cur, hold_w);
         if (fifo_rd_en) chk("no_underflow", fifo_empty, 0);
         if (tx_pkt_done) done_cnt++;
         if (axi_valid && axi_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) chk("sb_extra", exp_q.size(), 1);
            else                   chk("sb_word", cur, exp_q.pop_front());
         end
         hold_q = axi_valid && !axi_ready && rst_n;
         hold_w = cur;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rdv, vv;
      int hb, db;

      #3 rst_n = 1'b0;
      tick(); tick();
      chk("rst_valid", axi_valid, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_busy", tx_busy, 0);
      chk("rst_cnt", tx_pkt_cnt, 0);
      chk("rst_done", tx_pkt_done, 0);
      chk("rst_data", {axi_user, axi_keep, axi_last, axi_data}, 0);
      rst_n = 1'b1;
      tick();

      // 1: 4-word packet, full throughput
      for (int i = 0; i < 4; i++) push_word(8'h10 + 8'(i), i == 3, 10'h100 + 10'(i));
      tick();
      tx_en = 1'b1; axi_ready = 1'b1;
      db = done_cnt; hb = hs_cnt;
      rdv = '0; vv = '0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk_sys);
         rdv[k] = fifo_rd_en;
         vv[k]  = axi_valid;
      end
      chk("t1_rd_pattern", rdv, 16'h001E);
      chk("t1_valid_pattern", vv, 16'h0078);
      chk("t1_done_pulses", done_cnt - db, 1);
      chk("t1_hs", hs_cnt - hb, 4);
      chk("t1_pkt_cnt", tx_pkt_cnt, 1);

      // 2: backpressure for 6 cycles after first valid
      tick();
      axi_ready = 1'b0; hb = hs_cnt;
      for (int i = 0; i < 4; i++) push_word(8'h20 + 8'(i), i == 3, 10'h200 + 10'(i));
      for (int k = 0; k < 10 && !axi_valid; k++) @(negedge clk_sys);
      chk("bp_valid", axi_valid, 1);
      for (int j = 0; j < 6; j++) begin
         if (j > 0) @(negedge clk_sys);
         chk("bp_hold_data", axi_data, 8'h20);
      end
      chk("bp_buf_full", dut.buf_cnt, 3);
      chk("bp_rd_stop", fifo_rd_en, 0);
      chk("bp_fifo_left", wr_ptr - rd_ptr, 1);
      tick();
      axi_ready = 1'b1;
      wait_done(done_cnt + 1, 40);
      chk("bp_hs", hs_cnt - hb, 4);
      chk("bp_pkt_cnt", tx_pkt_cnt, 2);

      // 3: alternating ready, 8-word packet with random sideband
      hb = hs_cnt; db = done_cnt;
      for (int i = 0; i < 8; i++)
         push_word(8'($urandom_range(0, 255)), i == 7, 10'($urandom_range(0, 1023)));
      for (int k = 0; k < 100 && done_cnt == db; k++) begin
         tick();
         axi_ready = ~axi_ready;
      end
      chk("alt_done", done_cnt - db, 1);
      chk("alt_hs", hs_cnt - hb, 8);
      chk("alt_pkt_cnt", tx_pkt_cnt, 3);
      tick();
      axi_ready = 1'b1;

      // 4: tx_en dropped after word 2 of a 5-word packet
      hb = hs_cnt; db = done_cnt;
      for (int i = 0; i < 5; i++) push_word(8'h40 + 8'(i), i == 4, 10'h040 + 10'(i));
      wait_hs(hb + 2, 20);
      tx_en = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) push_word(8'h50 + 8'(i), i == 2, 10'h050 + 10'(i));
      wait_done(db + 1, 40);
      chk("stop_busy", tx_busy, 0);
      chk("stop_hs", hs_cnt - hb, 5);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_sys);
         chk("idle_no_rd", fifo_rd_en, 0);
      end
      chk("stop_fifo_left", wr_ptr - rd_ptr, 3);
      chk("stop_pkt_cnt", tx_pkt_cnt, 4);
      tick();
      tx_en = 1'b1;
      wait_done(db + 2, 40);
      chk("resume_pkt_cnt", tx_pkt_cnt, 5);

      // 5: FIFO runs dry mid-packet
      hb = hs_cnt; db = done_cnt;
      push_word(8'h60, 1'b0, 10'h060);
      push_word(8'h61, 1'b0, 10'h061);
      repeat (8) tick();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_sys);
         chk("gap_valid", axi_valid, 0);
      end
      chk("gap_hs", hs_cnt - hb, 2);
      tick();
      push_word(8'h62, 1'b0, 10'h062);
      push_word(8'h63, 1'b1, 10'h063);
      wait_done(db + 1, 40);
      chk("gap_total_hs", hs_cnt - hb, 4);
      chk("gap_pkt_cnt", tx_pkt_cnt, 6);

      // 6: async reset mid-packet; buffered/in-flight words are lost
      hb = hs_cnt;
      for (int i = 0; i < 6; i++) push_word(8'h70 + 8'(i), i == 5, 10'h070 + 10'(i));
      wait_hs(hb + 2, 20);
      rst_n = 1'b0;
      #1;
      chk("rstm_valid", axi_valid, 0);
      chk("rstm_rd_en", fifo_rd_en, 0);
      chk("rstm_cnt", tx_pkt_cnt, 0);
      exp_q.delete();
      for (int i = rd_ptr; i < wr_ptr; i++) exp_q.push_back(mem[i[7:0]]);
      chk("rstm_words_left", exp_q.size() != 0, 1);
      db = done_cnt;
      tick(); tick();
      rst_n = 1'b1;
      wait_done(db + 1, 40);
      chk("rstm_pkt_cnt", tx_pkt_cnt, 1);
      chk("sb_drained", exp_q.size(), 0);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
